control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired step sequencer for a simple CPU datapath.
// Walks a one-hot step vector T0..Tn per instruction, drives the common fetch
// controls in T0..T2, sizes each instruction from its opcode and handles
// halt, stop/resume and illegal-opcode reporting.
// Optional interrupt entry path: define CONTROL_SEQUENCER_IRQ_EN.
// All state is clocked on the falling edge of Clock.

module control_sequencer #(
    parameter int unsigned INT_NUM   = 4,
    parameter int unsigned MAX_STEPS = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Stop,
    input  logic                 Resume,
    input  logic [31:0]          IR,
    input  logic [INT_NUM-1:0]   Irq,
    input  logic                 IntEnable,
    output logic                 Run,
    output logic [MAX_STEPS-1:0] Step,
    output logic                 LastStep,
    output logic                 PCout,
    output logic                 MARin,
    output logic                 IncPC,
    output logic                 Zin,
    output logic                 Zlowout,
    output logic                 PCin,
    output logic                 Read,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 IRin,
    output logic [INT_NUM-1:0]   IntAck,
    output logic                 IntSave,
    output logic                 VecLoad,
    output logic [2:0]           IntVector,
    output logic                 IllegalOp
);

    localparam int unsigned      StepW    = $clog2(MAX_STEPS);
    localparam logic [StepW-1:0] StepLast = StepW'(MAX_STEPS - 1);
    localparam logic [StepW-1:0] StepIr   = StepW'(2);

    // Opcode map (IR[31:27])
    localparam logic [4:0] OpLd   = 5'd0;
    localparam logic [4:0] OpLdi  = 5'd1;
    localparam logic [4:0] OpSt   = 5'd2;
    localparam logic [4:0] OpAdd  = 5'd3;
    localparam logic [4:0] OpOri  = 5'd14;
    localparam logic [4:0] OpDiv  = 5'd15;
    localparam logic [4:0] OpMul  = 5'd16;
    localparam logic [4:0] OpNeg  = 5'd17;
    localparam logic [4:0] OpNot  = 5'd18;
    localparam logic [4:0] OpBr   = 5'd19;
    localparam logic [4:0] OpJal  = 5'd20;
    localparam logic [4:0] OpJr   = 5'd21;
    localparam logic [4:0] OpMflo = 5'd25;
    localparam logic [4:0] OpHalt = 5'd27;
    localparam logic [4:0] OpBad  = 5'd28;  // 28..31 are undefined

    typedef enum logic [1:0] {
        StClear    = 2'd0,
        StExec     = 2'd1,
`ifdef CONTROL_SEQUENCER_IRQ_EN
        StIntEntry = 2'd3,
`endif
        StHalted   = 2'd2
    } state_e;

    // Instruction length in steps; nop, halt and undefined opcodes take the bare fetch.
    function automatic logic [3:0] instr_len(input logic [4:0] op);
        logic [3:0] len;
        case (op) inside
            OpLd, OpSt:                   len = 4'd8;
            OpLdi, [OpAdd:OpOri], OpNeg,
            OpNot:                        len = 4'd6;
            OpDiv, OpMul, OpBr:           len = 4'd7;
            OpJal:                        len = 4'd5;
            [OpJr:OpMflo]:                len = 4'd4;
            default:                      len = 4'd3;
        endcase
        return len;
    endfunction

    state_e           state_q, state_d;
    logic [StepW-1:0] step_q, step_d;
    logic [4:0]       opcode_q, opcode_d;
    logic             illegal_q, illegal_d;

    logic [4:0]       cur_op;
    logic [3:0]       cur_len;
    logic             at_last;
    logic             is_halt;

    // Only the opcode field of IR is decoded here
    logic unused_ir;
    assign unused_ir = ^IR[26:0];

    // Decode length of the instruction in flight; at T2 the opcode is not latched yet
    always_comb begin
        cur_op  = (step_q == StepIr) ? IR[31:27] : opcode_q;
        cur_len = instr_len(cur_op);
        at_last = (int'(step_q) + 1 == int'(cur_len)) || (step_q == StepLast);
        is_halt = (cur_op == OpHalt);
    end

`ifdef CONTROL_SEQUENCER_IRQ_EN
    logic       irq_pend;
    logic [2:0] irq_idx;
    logic       int_cyc_q, int_cyc_d;
    logic [2:0] int_vec_q, int_vec_d;

    // Pending-request detect with lowest-index priority; requests are not latched
    always_comb begin
        irq_pend = IntEnable && (|Irq);
        irq_idx  = 3'd0;
        for (int i = int'(INT_NUM) - 1; i >= 0; i--) begin
            if (Irq[i]) begin
                irq_idx = 3'(i);
            end
        end
    end
`else
    logic unused_irq;
    assign unused_irq = ^{IntEnable, Irq};
`endif

    // Next-state, step counter and opcode latch
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        opcode_d  = opcode_q;
        illegal_d = 1'b0;
`ifdef CONTROL_SEQUENCER_IRQ_EN
        int_cyc_d = int_cyc_q;
        int_vec_d = int_vec_q;
`endif
        case (state_q)
            StClear: begin
                state_d = StExec;
                step_d  = '0;
            end
            StExec: begin
                if (step_q == StepIr) begin
                    opcode_d  = IR[31:27];
                    illegal_d = (IR[31:27] >= OpBad);
                end
                if (at_last) begin
                    step_d = '0;
                    // Halt and Stop outrank any pending interrupt
                    if (is_halt || Stop) begin
                        state_d = StHalted;
                    end
`ifdef CONTROL_SEQUENCER_IRQ_EN
                    else if (irq_pend) begin
                        state_d   = StIntEntry;
                        int_cyc_d = 1'b0;
                        int_vec_d = irq_idx;
                    end
`endif
                end else if (step_q != StepLast) begin
                    step_d = step_q + StepW'(1);
                end
            end
`ifdef CONTROL_SEQUENCER_IRQ_EN
            StIntEntry: begin
                if (int_cyc_q) begin
                    state_d   = StExec;
                    step_d    = '0;
                    int_cyc_d = 1'b0;
                end else begin
                    int_cyc_d = 1'b1;
                end
            end
`endif
            StHalted: begin
                if (Resume && !Stop) begin
                    state_d = StExec;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = StClear;
                step_d  = '0;
            end
        endcase
    end

    // State registers, falling-edge clocked with asynchronous clear
    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StClear;
            step_q    <= '0;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
`ifdef CONTROL_SEQUENCER_IRQ_EN
            int_cyc_q <= 1'b0;
            int_vec_q <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
`ifdef CONTROL_SEQUENCER_IRQ_EN
            int_cyc_q <= int_cyc_d;
            int_vec_q <= int_vec_d;
`endif
        end
    end

    // Step vector, fetch controls and status outputs
    always_comb begin
        Run       = 1'b0;
        Step      = '0;
        LastStep  = 1'b0;
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        IllegalOp = 1'b0;
        case (state_q)
            StExec: begin
                Run       = 1'b1;
                LastStep  = at_last;
                // illegal_q only lives for the cycle after the bad opcode's T2
                IllegalOp = illegal_q;
                for (int i = 0; i < int'(MAX_STEPS); i++) begin
                    Step[i] = (step_q == StepW'(i));
                end
                case (step_q)
                    StepW'(0): begin
                        PCout = 1'b1;
                        MARin = 1'b1;
                        IncPC = 1'b1;
                        Zin   = 1'b1;
                    end
                    StepW'(1): begin
                        Zlowout = 1'b1;
                        PCin    = 1'b1;
                        Read    = 1'b1;
                        MDRin   = 1'b1;
                    end
                    StepW'(2): begin
                        MDRout = 1'b1;
                        IRin   = 1'b1;
                    end
                    default: ;
                endcase
            end
`ifdef CONTROL_SEQUENCER_IRQ_EN
            StIntEntry: begin
                Run       = 1'b1;
                IllegalOp = illegal_q;
            end
`endif
            default: ;
        endcase
    end

`ifdef CONTROL_SEQUENCER_IRQ_EN
    // Interrupt entry: acknowledge and save in cycle 0, vector load in cycle 1
    always_comb begin
        IntAck    = '0;
        IntSave   = 1'b0;
        VecLoad   = 1'b0;
        IntVector = int_vec_q;
        if (state_q == StIntEntry) begin
            if (!int_cyc_q) begin
                for (int i = 0; i < int'(INT_NUM); i++) begin
                    IntAck[i] = (int_vec_q == 3'(i));
                end
                IntSave = 1'b1;
            end else begin
                VecLoad = 1'b1;
            end
        end
    end
`else
    assign IntAck    = '0;
    assign IntSave   = 1'b0;
    assign VecLoad   = 1'b0;
    assign IntVector = 3'd0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (default parameters).
// Each cycle's stimulus is driven just after the falling edge and the expected
// output vector is queued; outputs are popped and compared before the next edge.
// Interrupt expectations follow CONTROL_SEQUENCER_IRQ_EN when it is defined.

module tb_control_sequencer;

    typedef struct packed {
        logic       run;
        logic [7:0] step;
        logic       last;
        logic [9:0] fetch;  // PCout MARin IncPC Zin Zlowout PCin Read MDRin MDRout IRin
        logic [3:0] ack;
        logic       save;
        logic       vload;
        logic [2:0] vec;
        logic       ill;
    } vec_t;

    localparam logic [4:0] OpLd   = 5'd0;
    localparam logic [4:0] OpSt   = 5'd2;
    localparam logic [4:0] OpAdd  = 5'd3;
    localparam logic [4:0] OpMul  = 5'd16;
    localparam logic [4:0] OpJr   = 5'd21;
    localparam logic [4:0] OpNop  = 5'd26;
    localparam logic [4:0] OpHalt = 5'd27;
    localparam logic [4:0] OpBad  = 5'd30;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Stop = 1'b0;
    logic        Resume = 1'b0;
    logic [31:0] IR = '0;
    logic [3:0]  Irq = '0;
    logic        IntEnable = 1'b0;
    logic        Run, LastStep, IntSave, VecLoad, IllegalOp;
    logic [7:0]  Step;
    logic [3:0]  IntAck;
    logic [2:0]  IntVector;
    logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;

    int   checks = 0;
    int   errors = 0;
    logic [2:0] exp_vec = 3'd0;
    vec_t exp_q[$];
    vec_t obs, e;

    control_sequencer #(.INT_NUM(4), .MAX_STEPS(8)) dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .Resume(Resume), .IR(IR), .Irq(Irq),
        .IntEnable(IntEnable), .Run(Run), .Step(Step), .LastStep(LastStep),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .IntAck(IntAck), .IntSave(IntSave), .VecLoad(VecLoad), .IntVector(IntVector),
        .IllegalOp(IllegalOp)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t sample();
        vec_t v;
        v.run   = Run;
        v.step  = Step;
        v.last  = LastStep;
        v.fetch = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin};
        v.ack   = IntAck;
        v.save  = IntSave;
        v.vload = VecLoad;
        v.vec   = IntVector;
        v.ill   = IllegalOp;
        return v;
    endfunction

    function automatic vec_t ev_idle();
        vec_t v = '0;
        v.vec = exp_vec;
        return v;
    endfunction

    function automatic vec_t ev_exec(input int s, input bit last, input bit ill);
        vec_t v = '0;
        v.run  = 1'b1;
        v.step = 8'd1 << s;
        v.last = last;
        case (s)
            0:       v.fetch = 10'b1111000000;
            1:       v.fetch = 10'b0000111100;
            2:       v.fetch = 10'b0000000011;
            default: v.fetch = 10'b0;
        endcase
        v.vec = exp_vec;
        v.ill = ill;
        return v;
    endfunction

    function automatic vec_t ev_int(input int c);
        vec_t v = '0;
        v.run   = 1'b1;
        v.ack   = (c == 0) ? (4'd1 << exp_vec) : 4'd0;
        v.save  = (c == 0);
        v.vload = (c == 1);
        v.vec   = exp_vec;
        return v;
    endfunction

    // Start a cycle: drive inputs after the falling edge and queue the expectation
    task automatic drive(input logic rst, input logic [4:0] op, input logic stop,
                         input logic resume, input logic [3:0] irq, input logic ie,
                         input vec_t ev);
        @(negedge Clock);
        #1;
        Reset     = rst;
        IR        = {op, 27'($urandom)};
        Stop      = stop;
        Resume    = resume;
        Irq       = irq;
        IntEnable = ie;
        exp_q.push_back(ev);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clock);
        #1;
        exp_q.push_back(ev_idle());
        #1;
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, e); end
        // Release just after an edge: CLEAR must still be visible for this whole cycle
        drive(1'b1, OpAdd, 1'b0, 1'b0, 4'h0, 1'b0, ev_idle());
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL clear_cycle: got %h want %h", obs, e); end
    endtask

    task automatic test_add();
        for (int n = 0; n < 2; n++) begin
            for (int s = 0; s < 6; s++) begin
                drive(1'b1, OpAdd, 1'b0, 1'b0, 4'h0, 1'b0, ev_exec(s, s == 5, 1'b0));
                obs = sample(); e = exp_q.pop_front(); checks++;
                if (obs !== e) begin
                    errors++; $display("FAIL add n%0d T%0d: got %h want %h", n, s, obs, e);
                end
            end
        end
    endtask

    task automatic test_ld_jr();
        logic [4:0] ops[2];
        int lens[2];
        ops  = '{OpLd, OpJr};
        lens = '{8, 4};
        for (int n = 0; n < 2; n++) begin
            for (int s = 0; s < lens[n]; s++) begin
                drive(1'b1, ops[n], 1'b0, 1'b0, 4'h0, 1'b0, ev_exec(s, s == lens[n] - 1, 1'b0));
                obs = sample(); e = exp_q.pop_front(); checks++;
                if (obs !== e) begin
                    errors++; $display("FAIL ld_jr op%0d T%0d: got %h want %h", ops[n], s, obs, e);
                end
            end
        end
    endtask

    task automatic test_interrupt();
        for (int s = 0; s < 6; s++) begin
            drive(1'b1, OpAdd, 1'b0, 1'b0, 4'b0110, 1'b1, ev_exec(s, s == 5, 1'b0));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL irq_add T%0d: got %h want %h", s, obs, e); end
        end
`ifdef CONTROL_SEQUENCER_IRQ_EN
        exp_vec = 3'd1;  // lowest set request of 4'b0110
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, OpNop, 1'b0, 1'b0, 4'h0, 1'b0, ev_int(c));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL int_entry c%0d: got %h want %h", c, obs, e); end
        end
`endif
        // IntVector must hold after entry; a request dropped before LastStep is lost
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, OpNop, 1'b0, 1'b0, 4'h0, 1'b0, ev_exec(s, s == 2, 1'b0));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL post_int nop T%0d: got %h want %h", s, obs, e); end
        end
        for (int s = 0; s < 6; s++) begin
            drive(1'b1, OpAdd, 1'b0, 1'b0, (s < 4) ? 4'b0001 : 4'b0000, 1'b1,
                  ev_exec(s, s == 5, 1'b0));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL lost_irq T%0d: got %h want %h", s, obs, e); end
        end
    endtask

    task automatic test_stop_irq();
        for (int s = 0; s < 7; s++) begin
            drive(1'b1, OpMul, s >= 2, 1'b0, (s >= 2) ? 4'b0001 : 4'b0000, 1'b1,
                  ev_exec(s, s == 6, 1'b0));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL stop_mul T%0d: got %h want %h", s, obs, e); end
        end
        // Halted: resume under Stop ignored, idle cycle, then a real resume
        drive(1'b1, OpAdd, 1'b1, 1'b1, 4'b0001, 1'b1, ev_idle());
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL halted_stop_resume: got %h want %h", obs, e); end
        drive(1'b1, OpAdd, 1'b0, 1'b0, 4'h0, 1'b0, ev_idle());
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL halted_hold: got %h want %h", obs, e); end
        drive(1'b1, OpAdd, 1'b0, 1'b1, 4'h0, 1'b0, ev_idle());
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL halted_resume: got %h want %h", obs, e); end
    endtask

    task automatic test_illegal();
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, OpBad, 1'b0, 1'b0, 4'h0, 1'b0, ev_exec(s, s == 2, 1'b0));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL illegal T%0d: got %h want %h", s, obs, e); end
        end
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, OpNop, 1'b0, 1'b0, 4'h0, 1'b0, ev_exec(s, s == 2, s == 0));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL after_illegal T%0d: got %h want %h", s, obs, e); end
        end
    endtask

    task automatic test_halt();
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, OpHalt, 1'b0, 1'b0, 4'h0, 1'b0, ev_exec(s, s == 2, 1'b0));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL halt T%0d: got %h want %h", s, obs, e); end
        end
        drive(1'b1, OpSt, 1'b0, 1'b1, 4'h0, 1'b0, ev_idle());
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL halt_state: got %h want %h", obs, e); end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, OpSt, 1'b0, 1'b0, 4'h0, 1'b0, ev_exec(s, 1'b0, 1'b0));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL st T%0d: got %h want %h", s, obs, e); end
        end
        // Mid-cycle, away from any clock edge: outputs must clear at once
        #1;
        Reset   = 1'b0;
        exp_vec = 3'd0;
        exp_q.push_back(ev_idle());
        #1;
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL async_reset: got %h want %h", obs, e); end
        drive(1'b0, OpAdd, 1'b0, 1'b0, 4'h0, 1'b0, ev_idle());
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_held: got %h want %h", obs, e); end
        drive(1'b1, OpAdd, 1'b0, 1'b0, 4'h0, 1'b0, ev_idle());
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL clear_again: got %h want %h", obs, e); end
        for (int s = 0; s < 6; s++) begin
            drive(1'b1, OpAdd, 1'b0, 1'b0, 4'h0, 1'b0, ev_exec(s, s == 5, 1'b0));
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL restart add T%0d: got %h want %h", s, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld_jr();
        test_interrupt();
        test_stop_irq();
        test_illegal();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
